// File: rtl/m_cu_load.sv
`default_nettype none
// ============================================================================
// Module   : m_cu_load
// Brief    : Load-side memory control unit. Accepts a load request, issues
//            read transfers to the AXI master controller (one burst for
//            unit-stride, one element transfer per element for strided),
//            writes accepted beats into the load buffer, then drains the
//            buffer toward the lane array one lane group at a time.
// Revision : 1.0 - initial release
// ============================================================================
module m_cu_load #(
    parameter int VLEN               = 8192,
    parameter int V_LANE_NUM         = 8,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    localparam int VLW               = $clog2(VLEN) + 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    // scheduler request
    output logic                          mcu_ld_rdy_o,
    input  logic                          mcu_ld_vld_i,
    input  logic [31:0]                   mcu_base_addr_i,
    input  logic [31:0]                   mcu_stride_i,
    input  logic [2:0]                    mcu_data_width_i,
    input  logic [VLW-1:0]                mcu_vl_i,
    input  logic                          mcu_unit_ld_st_i,
    input  logic                          mcu_strided_ld_st_i,
    // AXI master controller
    output logic                          ctrl_rstart_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_raddr_o,
    output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_rxfer_size_o,
    input  logic                          ctrl_rdone_i,
    input  logic                          rd_tvalid_i,
    output logic                          rd_tready_o,
    input  logic                          rd_tlast_i,
    // load buffer array
    output logic                          lbuff_wen_o,
    input  logic                          lbuff_full_i,
    output logic                          lbuff_ren_o,
    output logic                          cfg_load_cntr_rst_o,
    output logic [2:0]                    cfg_data_sew_o,
    // lane array
    input  logic                          vlane_load_rdy_i,
    output logic                          vlane_load_valid_o,
    output logic                          vlane_load_last_o,
    // status
    output logic                          ld_err_o
);

    localparam int c_BB        = C_M_AXI_DATA_WIDTH / 8;
    localparam int c_BB_LOG2   = $clog2(c_BB);
    localparam int c_LANE_LOG2 = $clog2(V_LANE_NUM);
    localparam int c_GW        = VLW + 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_UNIT_START = 3'd1,
        S_UNIT_RX    = 3'd2,
        S_STR_START  = 3'd3,
        S_STR_RX     = 3'd4,
        S_DRAIN      = 3'd5
    } t_state;

    t_state                        r_state;
    logic [31:0]                   r_stride;
    logic [2:0]                    r_sew;
    logic [VLW-1:0]                r_vl;
    logic [VLW-1:0]                r_elem_idx;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr_acc;
    logic [C_XFER_SIZE_WIDTH-1:0]  r_beat_cnt;
    logic [c_GW-1:0]               r_issued;
    logic                          r_done_seen;
    logic                          r_beat_seen;
    logic                          r_valid;
    logic                          r_last;
    logic                          r_err;
    logic                          r_cfg_rst;

    logic [C_XFER_SIZE_WIDTH-1:0]  w_unit_size;
    logic [C_XFER_SIZE_WIDTH-1:0]  w_elem_size;
    logic [C_XFER_SIZE_WIDTH-1:0]  w_unit_beats;
    logic [c_GW-1:0]               w_groups;
    logic [VLW-1:0]                w_next_idx;
    logic                          w_in_rx;
    logic                          w_start;
    logic                          w_tready;
    logic                          w_beat;
    logic                          w_ren;
    logic                          w_legal;
    logic                          w_unit_err;
    logic                          w_done_now;
    logic                          w_beat_now;

    // Transfer geometry derived from the latched request
    assign w_unit_size  = C_XFER_SIZE_WIDTH'(r_vl) << r_sew;
    assign w_elem_size  = C_XFER_SIZE_WIDTH'(1) << r_sew;
    assign w_unit_beats = (w_unit_size + C_XFER_SIZE_WIDTH'(c_BB - 1)) >> c_BB_LOG2;
    assign w_groups     = (c_GW'(r_vl) + c_GW'(V_LANE_NUM - 1)) >> c_LANE_LOG2;
    assign w_next_idx   = r_elem_idx + VLW'(1);

    // Handshake decode; everything is forced low while reset is asserted
    assign w_in_rx    = (r_state == S_UNIT_RX) || (r_state == S_STR_RX);
    assign w_start    = (r_state == S_UNIT_START) || (r_state == S_STR_START);
    assign w_tready   = rstn && w_in_rx && !lbuff_full_i;
    assign w_beat     = w_tready && rd_tvalid_i;
    assign w_ren      = rstn && (r_state == S_DRAIN) && vlane_load_rdy_i && (r_issued < w_groups);
    assign w_legal    = (mcu_unit_ld_st_i || mcu_strided_ld_st_i) && (mcu_data_width_i <= 3'd2);

    // A beat is wrong if tlast lands early/late or the burst overruns its length
    assign w_unit_err = (rd_tlast_i && (r_beat_cnt != w_unit_beats - C_XFER_SIZE_WIDTH'(1)))
                        || (r_beat_cnt >= w_unit_beats);

    // Strided element completes once both the beat and rdone have been seen
    assign w_done_now = r_done_seen || ctrl_rdone_i;
    assign w_beat_now = r_beat_seen || w_beat;

    assign mcu_ld_rdy_o        = rstn && (r_state == S_IDLE);
    assign ctrl_rstart_o       = rstn && w_start;
    assign ctrl_raddr_o        = (rstn && w_start) ? r_addr_acc : '0;
    assign ctrl_rxfer_size_o   = !rstn                       ? '0 :
                                 (r_state == S_UNIT_START)   ? w_unit_size :
                                 (r_state == S_STR_START)    ? w_elem_size : '0;
    assign rd_tready_o         = w_tready;
    assign lbuff_wen_o         = w_beat;
    assign lbuff_ren_o         = w_ren;
    assign cfg_load_cntr_rst_o = rstn && r_cfg_rst;
    assign cfg_data_sew_o      = rstn ? r_sew : 3'd0;
    assign vlane_load_valid_o  = rstn && r_valid;
    assign vlane_load_last_o   = rstn && r_last;
    assign ld_err_o            = rstn && r_err;

    // Control FSM with request latching, beat accounting and drain sequencing
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_stride    <= '0;
            r_sew       <= '0;
            r_vl        <= '0;
            r_elem_idx  <= '0;
            r_addr_acc  <= '0;
            r_beat_cnt  <= '0;
            r_issued    <= '0;
            r_done_seen <= 1'b0;
            r_beat_seen <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_cfg_rst   <= 1'b0;
        end else begin
            r_cfg_rst <= 1'b0;
            // buffer read data appears one cycle after the read enable
            r_valid   <= w_ren;
            r_last    <= w_ren && (r_issued == w_groups - c_GW'(1));
            if (w_ren) begin
                r_issued <= r_issued + c_GW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (mcu_ld_vld_i && w_legal) begin
                        r_cfg_rst <= 1'b1;
                        if (mcu_vl_i != '0) begin
                            r_stride   <= mcu_stride_i;
                            r_sew      <= mcu_data_width_i;
                            r_vl       <= mcu_vl_i;
                            r_addr_acc <= C_M_AXI_ADDR_WIDTH'(mcu_base_addr_i);
                            r_elem_idx <= '0;
                            r_beat_cnt <= '0;
                            r_issued   <= '0;
                            r_err      <= 1'b0;
                            r_state    <= mcu_unit_ld_st_i ? S_UNIT_START : S_STR_START;
                        end
                    end
                end

                S_UNIT_START: begin
                    r_state <= S_UNIT_RX;
                end

                S_UNIT_RX: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + C_XFER_SIZE_WIDTH'(1);
                        if (w_unit_err) begin
                            r_err <= 1'b1;
                        end
                    end
                    if (ctrl_rdone_i) begin
                        r_state <= S_DRAIN;
                    end
                end

                S_STR_START: begin
                    r_done_seen <= 1'b0;
                    r_beat_seen <= 1'b0;
                    r_state     <= S_STR_RX;
                end

                S_STR_RX: begin
                    if (w_beat) begin
                        r_beat_seen <= 1'b1;
                        if (r_beat_seen) begin
                            r_err <= 1'b1;
                        end
                    end
                    if (ctrl_rdone_i) begin
                        r_done_seen <= 1'b1;
                    end
                    if (w_done_now && w_beat_now) begin
                        r_elem_idx <= w_next_idx;
                        r_addr_acc <= r_addr_acc + C_M_AXI_ADDR_WIDTH'($signed(r_stride));
                        r_state    <= (w_next_idx == r_vl) ? S_DRAIN : S_STR_START;
                    end
                end

                S_DRAIN: begin
                    if (r_last) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_cu_load.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_cu_load
// Brief    : Self-checking bench for m_cu_load with an AXI read responder,
//            a lane-ready driver, an output monitor and a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_cu_load;

    localparam int VLW   = $clog2(8192) + 1;
    localparam int LANES = 8;
    localparam int BB    = 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           mcu_ld_rdy_o;
    logic           mcu_ld_vld_i = 1'b0;
    logic [31:0]    mcu_base_addr_i = '0;
    logic [31:0]    mcu_stride_i = '0;
    logic [2:0]     mcu_data_width_i = '0;
    logic [VLW-1:0] mcu_vl_i = '0;
    logic           mcu_unit_ld_st_i = 1'b0;
    logic           mcu_strided_ld_st_i = 1'b0;
    logic           ctrl_rstart_o;
    logic [31:0]    ctrl_raddr_o;
    logic [31:0]    ctrl_rxfer_size_o;
    logic           ctrl_rdone_i;
    logic           rd_tvalid_i;
    logic           rd_tready_o;
    logic           rd_tlast_i;
    logic           lbuff_wen_o;
    logic           lbuff_full_i;
    logic           lbuff_ren_o;
    logic           cfg_load_cntr_rst_o;
    logic [2:0]     cfg_data_sew_o;
    logic           vlane_load_rdy_i;
    logic           vlane_load_valid_o;
    logic           vlane_load_last_o;
    logic           ld_err_o;

    always #5 clk = ~clk;

    m_cu_load dut (
        .clk                 (clk),
        .rstn                (rstn),
        .mcu_ld_rdy_o        (mcu_ld_rdy_o),
        .mcu_ld_vld_i        (mcu_ld_vld_i),
        .mcu_base_addr_i     (mcu_base_addr_i),
        .mcu_stride_i        (mcu_stride_i),
        .mcu_data_width_i    (mcu_data_width_i),
        .mcu_vl_i            (mcu_vl_i),
        .mcu_unit_ld_st_i    (mcu_unit_ld_st_i),
        .mcu_strided_ld_st_i (mcu_strided_ld_st_i),
        .ctrl_rstart_o       (ctrl_rstart_o),
        .ctrl_raddr_o        (ctrl_raddr_o),
        .ctrl_rxfer_size_o   (ctrl_rxfer_size_o),
        .ctrl_rdone_i        (ctrl_rdone_i),
        .rd_tvalid_i         (rd_tvalid_i),
        .rd_tready_o         (rd_tready_o),
        .rd_tlast_i          (rd_tlast_i),
        .lbuff_wen_o         (lbuff_wen_o),
        .lbuff_full_i        (lbuff_full_i),
        .lbuff_ren_o         (lbuff_ren_o),
        .cfg_load_cntr_rst_o (cfg_load_cntr_rst_o),
        .cfg_data_sew_o      (cfg_data_sew_o),
        .vlane_load_rdy_i    (vlane_load_rdy_i),
        .vlane_load_valid_o  (vlane_load_valid_o),
        .vlane_load_last_o   (vlane_load_last_o),
        .ld_err_o            (ld_err_o)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    // responder / lane configuration
    int sl_done_mode = 0;   // 0: rdone after last beat, 1: before first beat, 2: with last beat
    int sl_tlast_at  = 0;   // 0: tlast on final beat, else tlast on this beat number
    bit sl_bp        = 1'b0;
    int rdy_mode     = 0;   // 0: always ready, 1: toggle, 2: random

    // monitor results
    int          mon_wen, mon_ren, mon_val, mon_last, mon_last_idx, mon_cfg;
    int unsigned mon_last_cyc;
    logic [31:0] q_addr[$];
    logic [31:0] q_size[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // lane-side ready pattern
    initial begin
        vlane_load_rdy_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       vlane_load_rdy_i = 1'b1;
                1:       vlane_load_rdy_i = ~vlane_load_rdy_i;
                default: vlane_load_rdy_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // output monitor
    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (ctrl_rstart_o) begin
                q_addr.push_back(ctrl_raddr_o);
                q_size.push_back(ctrl_rxfer_size_o);
            end
            if (lbuff_wen_o)         mon_wen++;
            if (lbuff_ren_o)         mon_ren++;
            if (cfg_load_cntr_rst_o) mon_cfg++;
            if (vlane_load_valid_o) begin
                mon_val++;
                if (vlane_load_last_o) begin
                    mon_last++;
                    mon_last_idx = mon_val;
                    mon_last_cyc = cyc;
                end
            end else if (vlane_load_last_o) begin
                mon_last++;
            end
        end
    end

    // AXI read-side responder: answers every rstart with its beats and rdone
    initial begin : axi_slave
        int nb;
        bit ab;
        rd_tvalid_i = 1'b0; rd_tlast_i = 1'b0; ctrl_rdone_i = 1'b0; lbuff_full_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && ctrl_rstart_o) begin
                nb = (int'(ctrl_rxfer_size_o) + BB - 1) / BB;
                ab = 1'b0;
                if (sl_done_mode == 1) begin
                    @(posedge clk); #1 ctrl_rdone_i = 1'b1;
                    @(posedge clk); #1 ctrl_rdone_i = 1'b0;
                end
                for (int b = 1; b <= nb && !ab; b++) begin
                    @(posedge clk); #1;
                    rd_tvalid_i  = 1'b1;
                    rd_tlast_i   = (sl_tlast_at != 0) ? (b == sl_tlast_at) : (b == nb);
                    ctrl_rdone_i = (sl_done_mode == 2) && (b == nb);
                    if (sl_bp && b >= 5 && b <= 9) begin
                        lbuff_full_i = 1'b1;
                        repeat (2) begin
                            @(negedge clk);
                            chk("tready_while_full", rd_tready_o, 0);
                            chk("wen_while_full", lbuff_wen_o, 0);
                        end
                        @(posedge clk); #1 lbuff_full_i = 1'b0;
                    end
                    do begin
                        @(negedge clk);
                        if (rstn) chk("tready_not_full", rd_tready_o, 1);
                    end while (rstn && !rd_tready_o);
                    if (!rstn) ab = 1'b1;
                end
                @(posedge clk); #1;
                rd_tvalid_i = 1'b0; rd_tlast_i = 1'b0; ctrl_rdone_i = 1'b0;
                if (sl_done_mode == 0 && !ab) begin
                    ctrl_rdone_i = 1'b1;
                    @(posedge clk); #1 ctrl_rdone_i = 1'b0;
                end
            end
        end
    end

    task automatic clear_mon();
        mon_wen = 0; mon_ren = 0; mon_val = 0; mon_last = 0; mon_last_idx = 0; mon_cfg = 0;
        mon_last_cyc = 0;
        q_addr.delete();
        q_size.delete();
    endtask

    task automatic issue(input logic [31:0] base, input logic [31:0] stride, input logic [2:0] w,
                         input int vl, input bit unit, input bit str);
        @(posedge clk); #1;
        mcu_ld_vld_i        = 1'b1;
        mcu_base_addr_i     = base;
        mcu_stride_i        = stride;
        mcu_data_width_i    = w;
        mcu_vl_i            = VLW'(vl);
        mcu_unit_ld_st_i    = unit;
        mcu_strided_ld_st_i = str;
        @(negedge clk);
        chk("rdy_at_accept", mcu_ld_rdy_o, 1);
        @(posedge clk); #1 mcu_ld_vld_i = 1'b0;
    endtask

    // Full legal request: model the expected transfers, run it, compare
    task automatic run_req(input logic [31:0] base, input logic [31:0] stride, input logic [2:0] w,
                           input int vl, input bit unit, input bit str, input bit exp_err);
        logic [31:0] ea[$];
        logic [31:0] es[$];
        logic [31:0] a;
        int          exp_wr, exp_grp, t;
        if (unit) begin
            ea.push_back(base);
            es.push_back(32'(vl << w));
            exp_wr = ((vl << w) + BB - 1) / BB;
        end else begin
            a = base;
            for (int i = 0; i < vl; i++) begin
                ea.push_back(a);
                es.push_back(32'(1 << w));
                a = a + stride;
            end
            exp_wr = vl;
        end
        exp_grp = (vl + LANES - 1) / LANES;
        clear_mon();
        issue(base, stride, w, vl, unit, str);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mcu_ld_rdy_o && t < 3000);
        #1;
        chk("complete_in_budget", t < 3000, 1);
        chk("rdy_one_after_last", cyc - mon_last_cyc, 1);
        chk("rstart_count", q_addr.size(), ea.size());
        for (int i = 0; i < ea.size(); i++) begin
            if (i < q_addr.size()) begin
                chk("rstart_addr", q_addr[i], ea[i]);
                chk("rstart_size", q_size[i], es[i]);
            end
        end
        chk("lbuff_writes", mon_wen, exp_wr);
        chk("lbuff_reads", mon_ren, exp_grp);
        chk("lane_valids", mon_val, exp_grp);
        chk("lane_last_count", mon_last, 1);
        chk("lane_last_position", mon_last_idx, exp_grp);
        chk("cfg_rst_pulses", mon_cfg, 1);
        chk("ld_err", ld_err_o, exp_err);
        chk("sew_latched", cfg_data_sew_o, w);
        chk("tready_idle", rd_tready_o, 0);
    endtask

    initial begin : main
        bit          ru, rs;
        logic [2:0]  rw;
        int          rvl, t;

        // reset state
        clear_mon();
        repeat (3) begin
            @(negedge clk);
            chk("outputs_in_reset", |{mcu_ld_rdy_o, ctrl_rstart_o, ctrl_raddr_o, ctrl_rxfer_size_o,
                rd_tready_o, lbuff_wen_o, lbuff_ren_o, cfg_load_cntr_rst_o, cfg_data_sew_o,
                vlane_load_valid_o, vlane_load_last_o, ld_err_o}, 0);
        end
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", mcu_ld_rdy_o, 1);
        chk("err_after_reset", ld_err_o, 0);
        chk("tready_after_reset", rd_tready_o, 0);

        // unit-stride load
        run_req(32'h1000, 32'd0, 3'd2, 16, 1'b1, 1'b0, 1'b0);

        // strided: rdone before the beat, then rdone together with the beat
        sl_done_mode = 1;
        run_req(32'h2000, 32'd12, 3'd1, 4, 1'b0, 1'b1, 1'b0);
        sl_done_mode = 2;
        run_req(32'h2000, 32'd12, 3'd1, 4, 1'b0, 1'b1, 1'b0);
        sl_done_mode = 0;
        run_req(32'h3001, 32'hFFFF_FFF0, 3'd0, 11, 1'b0, 1'b1, 1'b0);

        // backpressure on the buffer and toggling lane ready
        sl_bp = 1'b1; rdy_mode = 1;
        run_req(32'h1000, 32'd0, 3'd2, 16, 1'b1, 1'b0, 1'b0);
        sl_bp = 1'b0; rdy_mode = 0;

        // illegal width and missing type flag are swallowed
        clear_mon();
        issue(32'h4000, 32'd4, 3'd3, 8, 1'b1, 1'b0);
        issue(32'h4000, 32'd4, 3'd2, 8, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("illegal_rdy_stays", mcu_ld_rdy_o, 1);
        end
        #1;
        chk("illegal_no_rstart", q_addr.size(), 0);
        chk("illegal_no_cfg_rst", mon_cfg, 0);

        // empty request: counter reset pulse only
        clear_mon();
        issue(32'h5000, 32'd0, 3'd2, 0, 1'b1, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("empty_rdy_stays", mcu_ld_rdy_o, 1);
        end
        #1;
        chk("empty_cfg_rst", mon_cfg, 1);
        chk("empty_no_rstart", q_addr.size(), 0);
        chk("empty_no_valid", mon_val, 0);

        // early tlast raises the sticky error until the next accept
        sl_tlast_at = 6;
        run_req(32'h6000, 32'd0, 3'd2, 8, 1'b1, 1'b0, 1'b1);
        sl_tlast_at = 0;
        repeat (3) @(negedge clk);
        chk("err_sticky", ld_err_o, 1);
        run_req(32'h6100, 32'd0, 3'd0, 5, 1'b1, 1'b0, 1'b0);

        // reset in the middle of a unit burst
        clear_mon();
        issue(32'h7000, 32'd0, 3'd2, 16, 1'b1, 1'b0);
        t = 0;
        do begin
            @(negedge clk); #1;
            t++;
        end while (mon_wen < 3 && t < 500);
        chk("beat3_in_budget", t < 500, 1);
        @(posedge clk); #1 rstn = 1'b0;
        @(negedge clk);
        chk("outputs_mid_reset", |{mcu_ld_rdy_o, ctrl_rstart_o, ctrl_raddr_o, ctrl_rxfer_size_o,
            rd_tready_o, lbuff_wen_o, lbuff_ren_o, cfg_load_cntr_rst_o, cfg_data_sew_o,
            vlane_load_valid_o, vlane_load_last_o, ld_err_o}, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        chk("rdy_after_mid_reset", mcu_ld_rdy_o, 1);
        chk("tready_after_mid_reset", rd_tready_o, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("writes_abandoned", mon_wen, 3);
        chk("no_restart_after_reset", q_addr.size(), 1);
        run_req(32'h7100, 32'd0, 3'd2, 16, 1'b1, 1'b0, 1'b0);

        // randomized requests
        for (int k = 0; k < 10; k++) begin
            ru  = 1'($urandom_range(0, 1));
            rs  = ru ? 1'($urandom_range(0, 1)) : 1'b1;
            rw  = 3'($urandom_range(0, 2));
            rvl = ru ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 10));
            sl_done_mode = ru ? 0 : int'($urandom_range(0, 2));
            sl_bp        = ru && ($urandom_range(0, 1) == 1);
            rdy_mode     = int'($urandom_range(0, 2));
            run_req($urandom, $urandom, rw, rvl, ru, rs, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_cu_load.md
Name: m_cu_load

Overview:
- Load-side memory control unit of the vector core; mirror of the store control path.
- Accepts a load request from the scheduler and issues read bursts to AXIM_CTRL: one unit-stride burst, or one single-element transfer per element for strided loads.
- Accepted read beats are written into the load buffer array.
- The load buffer is then drained toward the V_LANE array in lane-group reads.

Parameters:
- VLEN, 8192, vector register length in bits; sets element-count width VLW = $clog2(VLEN)+1.
- V_LANE_NUM, 8, elements delivered per load-buffer read (one per lane).
- C_M_AXI_ADDR_WIDTH, 32, read address width.
- C_M_AXI_DATA_WIDTH, 32, read beat width; beat bytes BB = C_M_AXI_DATA_WIDTH/8.
- C_XFER_SIZE_WIDTH, 32, transfer-size width in bytes.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- mcu_ld_rdy_o  out  1  request accepted when high together with mcu_ld_vld_i.
- mcu_ld_vld_i  in  1  load request valid.
- mcu_base_addr_i  in  32  base byte address.
- mcu_stride_i  in  32  byte stride, two's complement.
- mcu_data_width_i  in  3  element width code: 0 = 8b, 1 = 16b, 2 = 32b; 3..7 illegal.
- mcu_vl_i  in  VLW  element count.
- mcu_unit_ld_st_i  in  1  unit-stride load.
- mcu_strided_ld_st_i  in  1  strided load.
- ctrl_rstart_o  out  1  one-cycle read start pulse.
- ctrl_raddr_o  out  C_M_AXI_ADDR_WIDTH  transfer start address.
- ctrl_rxfer_size_o  out  C_XFER_SIZE_WIDTH  transfer size in bytes.
- ctrl_rdone_i  in  1  transfer complete pulse.
- rd_tvalid_i  in  1  read beat valid.
- rd_tready_o  out  1  read beat ready.
- rd_tlast_i  in  1  last beat of transfer.
- lbuff_wen_o  out  1  load-buffer write enable (one beat).
- lbuff_full_i  in  1  load buffer cannot accept a beat.
- lbuff_ren_o  out  1  load-buffer read enable (one lane group).
- cfg_load_cntr_rst_o  out  1  one-cycle pulse resetting buffer pointers.
- cfg_data_sew_o  out  3  latched element width code for the buffer array.
- vlane_load_rdy_i  in  1  lanes can take a group.
- vlane_load_valid_o  out  1  lane group valid.
- vlane_load_last_o  out  1  final lane group of the request.
- ld_err_o  out  1  sticky beat-count/tlast mismatch flag.

Behaviour:
- Reset (rstn low at clk edge):
  - State goes to IDLE; all counters and latched configuration clear.
  - Every output is 0, including mcu_ld_rdy_o while rstn is low.
  - Reset mid-transfer abandons the transfer with no further rstart or lbuff writes; AXIM_CTRL is reset by the same rstn.
- States: IDLE, UNIT_START, UNIT_RX, STR_START, STR_RX, DRAIN.
- IDLE:
  - mcu_ld_rdy_o = 1.
  - On vld&&rdy: latch base, stride, width, vl; pulse cfg_load_cntr_rst_o; clear ld_err_o.
  - Next state: UNIT_START if unit, else STR_START if strided; unit has priority if both are set.
  - Neither type flag set, or width code > 2: request is consumed, no other action, stay in IDLE.
  - vl = 0: pulse cfg_load_cntr_rst_o only; remain IDLE. No rstart, no lane valid.
- UNIT_START (1 cycle):
  - ctrl_rstart_o = 1, ctrl_raddr_o = base, ctrl_rxfer_size_o = vl << width.
  - expected beats = ceil(size/BB).
  - Next state: UNIT_RX.
- UNIT_RX:
  - rd_tready_o = !lbuff_full_i; lbuff_wen_o = rd_tvalid_i && rd_tready_o.
  - Beat counter increments per accepted beat.
  - Accepted rd_tlast_i with count != expected-1, or a beat accepted beyond expected: set ld_err_o. Extra beats are still written.
  - ctrl_rdone_i: go to DRAIN. If done arrives in the same cycle as the final beat, that beat is written before leaving.
- STR_START (1 cycle):
  - ctrl_rstart_o = 1, ctrl_raddr_o = addr_acc, ctrl_rxfer_size_o = 1 << width.
  - addr_acc = base on entry from IDLE; stride is added after each element; address arithmetic wraps mod 2^C_M_AXI_ADDR_WIDTH.
- STR_RX:
  - Same ready/write rules as UNIT_RX; exactly one beat is expected per element.
  - ctrl_rdone_i and the beat may arrive in either order or together; track each with a flag. Leave only when both are seen.
  - Then element index++: if index == vl go to DRAIN, else go to STR_START.
  - Strided element addresses are assumed not to cross a beat boundary; unaligned addresses are forwarded unchanged.
- DRAIN:
  - groups = ceil(vl/V_LANE_NUM); lbuff_ren_o = vlane_load_rdy_i while issued < groups.
  - Buffer read latency is 1: vlane_load_valid_o is lbuff_ren_o registered one cycle.
  - vlane_load_last_o accompanies the valid of the final group.
  - State goes to IDLE in the cycle after last valid, so mcu_ld_rdy_o returns 1 one cycle after last.
  - vlane_load_rdy_i low stalls issue only; no valid is dropped.
- rd_tready_o is 0 outside the RX states. Beats arriving then are not accepted.
- cfg_data_sew_o holds the latched width until the next accept.

Test Plan:
- Unit load: vl=16, width=2, base=0x1000, BB=4, V_LANE_NUM=8, lanes always ready.
  - One rstart: addr 0x1000, size 64.
  - 16 lbuff_wen pulses.
  - 2 lane valids, last on the 2nd; rdy back 1 cycle later.
- Strided load: vl=4, width=1, stride=12, base=0x2000.
  - Rstart addrs 0x2000, 0x200C, 0x2018, 0x2024, size 2 each.
  - Run once with rdone before the beat and once with rdone coincident with the beat; both give 4 writes and no error.
- Backpressure: unit vl=16 with lbuff_full_i high for beats 5–9 and vlane_load_rdy_i toggling.
  - rd_tready_o low exactly while full.
  - No lost or duplicated writes or groups; still 16 writes and 2 valids.
- Illegal and empty requests:
  - width=3 consumed: no rstart, stays IDLE.
  - vl=0 unit: only the cfg_load_cntr_rst_o pulse, rdy stays 1.
- Error: unit vl=8, width=2 (8 beats expected) with tlast on beat 6 → ld_err_o = 1 and stays high until the next accept.
- Reset mid-RX: rstn low for 1 cycle after beat 3 of 16.
  - All outputs 0 during reset, rdy = 1 next cycle.
  - A new unit request completes normally.
